vga_line_feeder: RTL and testbench

Producer side of the VGA scanline buffer. On each end-of-line pulse from the VGA output block it pulls one line of 12-bit RGB pixels from an upstream renderer over a valid/ready stream. It drives the pixel column, write data and line index that the VGA block writes into its line buffer. It tracks the current line and frame, and flags lines that were not fully delivered before the next line-end.

---
 rtl/vga_line_feeder.sv | 98 +++++++++
 tb/tb_vga_line_feeder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_feeder.sv
// rtl/vga_line_feeder.sv - pulls one scanline of pixels per line-end and feeds the VGA line buffer
module vga_line_feeder #(
    parameter int WIDTH  = 1024,
    parameter int HEIGHT = 768,
    parameter int DATA_W = 12
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              lineend_in,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [10:0]       x,
    output logic [11:0]       y,
    output logic [DATA_W-1:0] data_out,
    output logic              wr_en,
    output logic              line_done,
    output logic              frame_start,
    output logic              underrun
);

    localparam logic [10:0] COL_LAST = 11'(WIDTH - 1);
    localparam logic [11:0] Y_LAST   = 12'(HEIGHT - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t      state, state_nx;
    logic [10:0] col, col_nx;
    logic [11:0] y_nx, y_inc;
    logic        lineend_q;
    logic        rise, xfer, last;
    logic        fs_nx, ur_nx;

    always_comb begin
        rise     = lineend_in & ~lineend_q;
        xfer     = s_valid & s_ready;
        last     = xfer & (col == COL_LAST);
        y_inc    = (y == Y_LAST) ? 12'd0 : y + 12'd1;
        state_nx = state;
        col_nx   = col;
        y_nx     = y;
        fs_nx    = 1'b0;
        ur_nx    = underrun;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = FILL;
                    col_nx   = 11'd0;
                    fs_nx    = (y == 12'd0);
                end
            end
            FILL: begin
                // A line-end always closes the line; it only counts as underrun if the last pixel missed it
                if (last || rise) begin
                    y_nx     = y_inc;
                    col_nx   = 11'd0;
                    state_nx = rise ? FILL : IDLE;
                    fs_nx    = rise & (y_inc == 12'd0);
                    ur_nx    = underrun | (rise & ~last);
                end else if (xfer) begin
                    col_nx = col + 11'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            col         <= 11'd0;
            y           <= 12'd0;
            lineend_q   <= 1'b0;
            s_ready     <= 1'b0;
            x           <= 11'd0;
            data_out    <= '0;
            wr_en       <= 1'b0;
            line_done   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nx;
            col         <= col_nx;
            y           <= y_nx;
            lineend_q   <= lineend_in;
            s_ready     <= (state_nx == FILL);
            wr_en       <= xfer;
            line_done   <= last;
            frame_start <= fs_nx;
            underrun    <= ur_nx;
            if (xfer) begin
                x        <= col;
                data_out <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_vga_line_feeder.sv
// tb/tb_vga_line_feeder.sv - randomized scoreboard bench for vga_line_feeder
module tb_vga_line_feeder;

    localparam int WIDTH  = 1024;
    localparam int HEIGHT = 768;
    localparam int DATA_W = 12;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              lineend_in;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [10:0]       x;
    logic [11:0]       y;
    logic [DATA_W-1:0] data_out;
    logic              wr_en;
    logic              line_done;
    logic              frame_start;
    logic              underrun;

    vga_line_feeder #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .lineend_in(lineend_in), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .x(x), .y(y), .data_out(data_out),
        .wr_en(wr_en), .line_done(line_done), .frame_start(frame_start),
        .underrun(underrun)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: line/pixel bookkeeping with plain integers
    typedef struct {
        int x;
        int data;
        bit last;
        int yafter;
    } exp_t;

    exp_t wq[$];
    bit   m_prev_le, m_in_line, m_underrun, m_fs_exp;
    int   m_col, m_line, m_fs_total;
    bit   md_rise, md_acc, md_last;
    int   fs_seen = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_prev_le  = 0;
            m_in_line  = 0;
            m_underrun = 0;
            m_fs_exp   = 0;
            m_col      = 0;
            m_line     = 0;
            wq.delete();
        end else begin
            md_rise   = lineend_in && !m_prev_le;
            m_prev_le = lineend_in;
            md_acc    = s_valid && s_ready;
            m_fs_exp  = 0;
            if (md_acc) begin
                md_last = (m_col == WIDTH - 1);
                if (md_last || md_rise) m_line = (m_line + 1) % HEIGHT;
                if (md_rise && !md_last) m_underrun = 1;
                wq.push_back('{m_col, int'(s_data), md_last, m_line});
                if (md_last || md_rise) m_col = 0;
                else m_col = m_col + 1;
                if (md_last) m_in_line = md_rise;
            end else if (md_rise) begin
                if (m_in_line) begin
                    m_underrun = 1;
                    m_line = (m_line + 1) % HEIGHT;
                end
                m_in_line = 1;
                m_col = 0;
            end
            if (md_rise && m_line == 0) begin
                m_fs_exp = 1;
                m_fs_total++;
            end
        end
    end

    // Monitor: compares DUT outputs against the model between clock edges
    exp_t e;
    always @(negedge CLK) begin
        if (RST_N) begin
            check("s_ready", s_ready, m_in_line);
            check("frame_start", frame_start, m_fs_exp);
            if (frame_start) fs_seen++;
            check("wr_en", wr_en, wq.size() != 0);
            if (wr_en && wq.size() != 0) begin
                e = wq.pop_front();
                check("x", x, e.x);
                check("data_out", data_out, e.data);
                check("line_done", line_done, e.last);
                check("y", y, e.yafter);
                check("underrun", underrun, m_underrun);
            end else begin
                check("line_done_nowr", line_done, 0);
            end
        end
    end

    task automatic raise_le();
        @(negedge CLK);
        s_valid    = 0;
        lineend_in = 1;
        @(negedge CLK);
        lineend_in = 0;
    endtask

    task automatic send_pixels(input int n, input int pct, input bit rise_last, input bit ramp);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < 20000) begin
            @(negedge CLK);
            guard++;
            lineend_in = 0;
            s_valid    = ($urandom_range(99) < pct);
            s_data     = ramp ? DATA_W'(sent) : DATA_W'($urandom);
            if (rise_last && sent == n - 1 && s_ready) begin
                s_valid    = 1;
                lineend_in = 1;
            end
            if (s_valid && s_ready) sent++;
        end
        check("send_done", sent, n);
        @(negedge CLK);
        s_valid    = 0;
        lineend_in = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N      = 0;
        lineend_in = 0;
        s_valid    = 0;
        s_data     = '0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {s_ready, x, y, data_out, wr_en, line_done, frame_start, underrun}, 0);
        RST_N = 1;

        // Start line 0, then reset asynchronously mid-line
        raise_le();
        send_pixels(10, 100, 0, 1);
        @(negedge CLK);
        #2 RST_N = 0;
        #1 check("async_reset_outputs",
                 {s_ready, x, y, data_out, wr_en, line_done, frame_start, underrun}, 0);
        @(negedge CLK);
        RST_N = 1;

        // Full-rate line 0 with ramp data
        raise_le();
        send_pixels(WIDTH, 100, 0, 1);
        @(negedge CLK);
        check("y_after_line0", y, 1);
        check("ready_low_after_line", s_ready, 0);

        // Backpressured line 1
        raise_le();
        send_pixels(WIDTH, 50, 0, 0);

        // Line 2 ends with a rise coincident with the final transfer
        raise_le();
        send_pixels(WIDTH, 75, 1, 0);
        check("no_underrun_coincident", underrun, 0);
        check("ready_after_coincident", s_ready, 1);
        send_pixels(WIDTH, 75, 0, 0);

        // Underrun on line 4
        raise_le();
        send_pixels(500, 80, 0, 0);
        raise_le();
        @(negedge CLK);
        check("underrun_set", underrun, 1);
        send_pixels(WIDTH, 90, 0, 0);

        // Advance quickly to the last line, then complete it and wrap
        for (int i = 0; i < 2000 && m_line != HEIGHT - 1; i++) raise_le();
        check("reach_last_line", m_line, HEIGHT - 1);
        send_pixels(WIDTH, 90, 0, 0);
        @(negedge CLK);
        check("y_wrapped", y, 0);
        raise_le();
        send_pixels(WIDTH, 90, 0, 1);
        repeat (2) @(negedge CLK);
        check("y_final", y, 1);
        check("underrun_sticky", underrun, 1);
        check("frame_start_count", fs_seen, 3);
        check("frame_start_model", fs_seen, m_fs_total);
        check("queue_empty", wq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
